data_sram_ctrl: RTL and testbench

//  Sequences the data-side SRAM-like bus for the load/store path: takes one access from EXE, drives req/addr until

---
 rtl/data_sram_ctrl_pkg.sv | 19 +
 rtl/data_sram_ctrl.sv | 107 ++++++++++
 tb/tb_data_sram_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_sram_ctrl_pkg.sv
// Shared encodings and default bus widths for the data-side SRAM controller.
package data_sram_ctrl_pkg;

  localparam int DSC_ADDR_W = 32;
  localparam int DSC_DATA_W = 32;
  localparam int SIZE_W     = 2;

  localparam logic [SIZE_W-1:0] SIZE_B = 2'd0;
  localparam logic [SIZE_W-1:0] SIZE_H = 2'd1;
  localparam logic [SIZE_W-1:0] SIZE_W_CODE = 2'd2;

  typedef enum logic [1:0] {
    DSC_IDLE = 2'd0,
    DSC_REQ  = 2'd1,
    DSC_WAIT = 2'd2,
    DSC_RESP = 2'd3
  } dsc_state_e;

endpackage

// File: rtl/data_sram_ctrl.sv
// Single-outstanding data-side bus sequencer: EXE access in, SRAM-like bus out,
// response to MEM with a zero-latency bypass and a one-entry holding register.
module data_sram_ctrl
  import data_sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = DSC_ADDR_W,
  parameter int DATA_W = DSC_DATA_W
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush,
  input  logic                es_req_valid,
  output logic                es_req_ready,
  input  logic                es_req_wr,
  input  logic [SIZE_W-1:0]   es_req_size,
  input  logic [ADDR_W-1:0]   es_req_addr,
  input  logic [DATA_W/8-1:0] es_req_wstrb,
  input  logic [DATA_W-1:0]   es_req_wdata,
  output logic                ms_resp_valid,
  input  logic                ms_resp_ready,
  output logic [DATA_W-1:0]   ms_resp_rdata,
  output logic                data_req,
  output logic                data_wr,
  output logic [SIZE_W-1:0]   data_size,
  output logic [ADDR_W-1:0]   data_addr,
  output logic [DATA_W/8-1:0] data_wstrb,
  output logic [DATA_W-1:0]   data_wdata,
  input  logic                data_addr_ok,
  input  logic                data_data_ok,
  input  logic [DATA_W-1:0]   data_rdata
);

  dsc_state_e        state;
  logic              cancel;
  logic [DATA_W-1:0] resp_buf;

  logic       data_ok_now;
  logic       drop;
  logic       resp_hit;
  dsc_state_e done_state;

  // addr_ok and data_ok in the same REQ cycle behave exactly like data_ok in WAIT.
  assign data_ok_now = data_data_ok &&
                       (state == DSC_WAIT || (state == DSC_REQ && data_addr_ok));
  assign drop        = cancel || flush;
  assign resp_hit    = resetn && data_ok_now && !drop;
  assign done_state  = (drop || ms_resp_ready) ? DSC_IDLE : DSC_RESP;

  assign es_req_ready  = resetn && (state == DSC_IDLE) && !flush;
  assign ms_resp_valid = resp_hit || (resetn && state == DSC_RESP);
  assign ms_resp_rdata = resp_hit ? data_rdata : resp_buf;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= DSC_IDLE;
      cancel     <= 1'b0;
      resp_buf   <= '0;
      data_req   <= 1'b0;
      data_wr    <= 1'b0;
      data_size  <= '0;
      data_addr  <= '0;
      data_wstrb <= '0;
      data_wdata <= '0;
    end else begin
      case (state)
        DSC_IDLE: begin
          if (es_req_valid && es_req_ready) begin
            data_req   <= 1'b1;
            data_wr    <= es_req_wr;
            data_size  <= es_req_size;
            data_addr  <= es_req_addr;
            data_wstrb <= es_req_wstrb;
            data_wdata <= es_req_wdata;
            state      <= DSC_REQ;
          end
        end
        DSC_REQ: begin
          // The request cannot be withdrawn once raised; flush only marks it for discard.
          if (flush) cancel <= 1'b1;
          if (data_addr_ok) begin
            data_req <= 1'b0;
            if (data_data_ok) begin
              cancel <= 1'b0;
              state  <= done_state;
            end else begin
              state  <= DSC_WAIT;
            end
          end
        end
        DSC_WAIT: begin
          if (data_data_ok) begin
            cancel <= 1'b0;
            state  <= done_state;
          end else if (flush) begin
            cancel <= 1'b1;
          end
        end
        DSC_RESP: begin
          if (flush || ms_resp_ready) state <= DSC_IDLE;
        end
        default: state <= DSC_IDLE;
      endcase
      if (resp_hit && !ms_resp_ready) resp_buf <= data_rdata;
    end
  end

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Directed bench for data_sram_ctrl: inputs driven after the falling edge,
// outputs sampled 1ns later, well away from the rising edge.
module tb_data_sram_ctrl;
  import data_sram_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        resetn, flush;
  logic        es_req_valid, es_req_ready, es_req_wr;
  logic [1:0]  es_req_size;
  logic [31:0] es_req_addr, es_req_wdata;
  logic [3:0]  es_req_wstrb;
  logic        ms_resp_valid, ms_resp_ready;
  logic [31:0] ms_resp_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_sram_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .es_req_valid(es_req_valid), .es_req_ready(es_req_ready), .es_req_wr(es_req_wr),
    .es_req_size(es_req_size), .es_req_addr(es_req_addr), .es_req_wstrb(es_req_wstrb),
    .es_req_wdata(es_req_wdata),
    .ms_resp_valid(ms_resp_valid), .ms_resp_ready(ms_resp_ready), .ms_resp_rdata(ms_resp_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  // Presents one access for a single cycle; returns in the first REQ cycle.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                       input logic [3:0] st, input logic [31:0] wd);
    es_req_valid = 1'b1; es_req_wr = wr; es_req_size = sz;
    es_req_addr = a; es_req_wstrb = st; es_req_wdata = wd;
    @(negedge clk);
    es_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; es_req_valid = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if ({data_req, ms_resp_valid, es_req_ready} !== 3'b000) begin
      failures++; $display("FAIL reset_ctl: got %b exp 000", {data_req, ms_resp_valid, es_req_ready});
    end
    checks++;
    if ({data_wr, data_size, data_addr, data_wstrb, data_wdata} !== 71'd0) begin
      failures++; $display("FAIL reset_fields: addr=%h wdata=%h", data_addr, data_wdata);
    end
    es_req_valid = 1'b0;
    @(negedge clk); resetn = 1'b1; #1;
    checks++;
    if (es_req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_release_ready: got %b exp 1", es_req_ready);
    end
  endtask

  task automatic test_load_bypass();
    issue(1'b0, SIZE_W_CODE, 32'h1c000100, 4'hf, 32'h0);
    data_addr_ok = 1'b1; #1;
    checks++;
    if ({data_req, data_wr, data_size, data_addr} !== {1'b1, 1'b0, 2'd2, 32'h1c000100}) begin
      failures++; $display("FAIL load_req: req=%b addr=%h exp req=1 addr=1c000100", data_req, data_addr);
    end
    @(negedge clk); data_addr_ok = 1'b0; #1;
    checks++;
    if (data_req !== 1'b0) begin
      failures++; $display("FAIL load_req_one_cycle: got %b exp 0", data_req);
    end
    @(negedge clk); #1;
    checks++;
    if (ms_resp_valid !== 1'b0) begin
      failures++; $display("FAIL load_wait_no_resp: got %b exp 0", ms_resp_valid);
    end
    @(negedge clk); data_data_ok = 1'b1; data_rdata = 32'hdeadbeef; ms_resp_ready = 1'b1; #1;
    checks++;
    if ({ms_resp_valid, ms_resp_rdata} !== {1'b1, 32'hdeadbeef}) begin
      failures++; $display("FAIL load_bypass: valid=%b rdata=%h exp 1 deadbeef", ms_resp_valid, ms_resp_rdata);
    end
    @(negedge clk); data_data_ok = 1'b0; data_rdata = 32'h0; #1;
    checks++;
    if ({ms_resp_valid, es_req_ready} !== 2'b01) begin
      failures++; $display("FAIL load_idle_after: valid/ready=%b exp 01", {ms_resp_valid, es_req_ready});
    end
  endtask

  task automatic test_load_stall();
    issue(1'b0, SIZE_W_CODE, 32'h1c000100, 4'hf, 32'h0);
    data_addr_ok = 1'b1;
    @(negedge clk); data_addr_ok = 1'b0;
    @(negedge clk); data_data_ok = 1'b1; data_rdata = 32'hdeadbeef; ms_resp_ready = 1'b0; #1;
    checks++;
    if ({ms_resp_valid, ms_resp_rdata} !== {1'b1, 32'hdeadbeef}) begin
      failures++; $display("FAIL stall_first: valid=%b rdata=%h", ms_resp_valid, ms_resp_rdata);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); data_data_ok = 1'b0; data_rdata = 32'h12345678;
      if (i == 2) ms_resp_ready = 1'b1;
      #1;
      checks++;
      if ({ms_resp_valid, ms_resp_rdata} !== {1'b1, 32'hdeadbeef}) begin
        failures++; $display("FAIL stall_hold%0d: valid=%b rdata=%h exp 1 deadbeef", i, ms_resp_valid, ms_resp_rdata);
      end
    end
    @(negedge clk); #1;
    checks++;
    if ({ms_resp_valid, es_req_ready} !== 2'b01) begin
      failures++; $display("FAIL stall_idle_after: valid/ready=%b exp 01", {ms_resp_valid, es_req_ready});
    end
  endtask

  task automatic test_store();
    issue(1'b1, SIZE_B, 32'h1c000202, 4'b0100, 32'h00ab0000);
    es_req_addr = 32'hffffffff; es_req_wdata = 32'h55555555; es_req_wstrb = 4'hf; es_req_wr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) data_addr_ok = 1'b1;
      #1;
      checks++;
      if ({data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata} !==
          {1'b1, 1'b1, 2'd0, 32'h1c000202, 4'b0100, 32'h00ab0000}) begin
        failures++; $display("FAIL store_fields%0d: req=%b addr=%h strb=%b wdata=%h", i, data_req, data_addr, data_wstrb, data_wdata);
      end
      @(negedge clk);
    end
    data_addr_ok = 1'b0; data_data_ok = 1'b1; ms_resp_ready = 1'b1; #1;
    checks++;
    if ({data_req, ms_resp_valid} !== 2'b01) begin
      failures++; $display("FAIL store_completion: req/valid=%b exp 01", {data_req, ms_resp_valid});
    end
    @(negedge clk); data_data_ok = 1'b0; #1;
    checks++;
    if ({ms_resp_valid, es_req_ready} !== 2'b01) begin
      failures++; $display("FAIL store_idle_after: valid/ready=%b exp 01", {ms_resp_valid, es_req_ready});
    end
  endtask

  task automatic test_flush_idle();
    flush = 1'b1; es_req_valid = 1'b1; es_req_addr = 32'h1c000300; #1;
    checks++;
    if (es_req_ready !== 1'b0) begin
      failures++; $display("FAIL flush_idle_ready: got %b exp 0", es_req_ready);
    end
    @(negedge clk); flush = 1'b0; es_req_valid = 1'b0; #1;
    checks++;
    if (data_req !== 1'b0) begin
      failures++; $display("FAIL flush_idle_no_req: got %b exp 0", data_req);
    end
  endtask

  task automatic test_flush_req();
    issue(1'b0, SIZE_W_CODE, 32'h1c000400, 4'hf, 32'h0);
    flush = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) data_addr_ok = 1'b1;
      #1;
      checks++;
      if (data_req !== 1'b1) begin
        failures++; $display("FAIL flush_req_hold%0d: got %b exp 1", i, data_req);
      end
      @(negedge clk); flush = 1'b0;
    end
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hcafef00d; ms_resp_ready = 1'b1; #1;
    checks++;
    if ({data_req, ms_resp_valid} !== 2'b00) begin
      failures++; $display("FAIL flush_req_dropped: req/valid=%b exp 00", {data_req, ms_resp_valid});
    end
    @(negedge clk); data_data_ok = 1'b0; #1;
    checks++;
    if ({ms_resp_valid, es_req_ready} !== 2'b01) begin
      failures++; $display("FAIL flush_req_idle: valid/ready=%b exp 01", {ms_resp_valid, es_req_ready});
    end
  endtask

  task automatic test_addr_data_same();
    issue(1'b0, SIZE_H, 32'h1c000502, 4'hf, 32'h0);
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h0badf00d; ms_resp_ready = 1'b1; #1;
    checks++;
    if ({ms_resp_valid, ms_resp_rdata} !== {1'b1, 32'h0badf00d}) begin
      failures++; $display("FAIL same_cycle_ok: valid=%b rdata=%h exp 1 0badf00d", ms_resp_valid, ms_resp_rdata);
    end
    @(negedge clk); data_addr_ok = 1'b0; data_data_ok = 1'b0; #1;
    checks++;
    if ({data_req, ms_resp_valid, es_req_ready} !== 3'b001) begin
      failures++; $display("FAIL same_cycle_idle: req/valid/ready=%b exp 001", {data_req, ms_resp_valid, es_req_ready});
    end
  endtask

  task automatic test_flush_wait_data_ok();
    issue(1'b0, SIZE_W_CODE, 32'h1c000600, 4'hf, 32'h0);
    data_addr_ok = 1'b1;
    @(negedge clk); data_addr_ok = 1'b0;
    data_data_ok = 1'b1; flush = 1'b1; data_rdata = 32'h77778888; ms_resp_ready = 1'b1; #1;
    checks++;
    if (ms_resp_valid !== 1'b0) begin
      failures++; $display("FAIL flush_wait_drop: got %b exp 0", ms_resp_valid);
    end
    @(negedge clk); data_data_ok = 1'b0; flush = 1'b0; #1;
    checks++;
    if ({ms_resp_valid, es_req_ready} !== 2'b01) begin
      failures++; $display("FAIL flush_wait_idle: valid/ready=%b exp 01", {ms_resp_valid, es_req_ready});
    end
  endtask

  task automatic test_flush_resp();
    issue(1'b0, SIZE_W_CODE, 32'h1c000700, 4'hf, 32'h0);
    data_addr_ok = 1'b1;
    @(negedge clk); data_addr_ok = 1'b0;
    data_data_ok = 1'b1; data_rdata = 32'h11112222; ms_resp_ready = 1'b0;
    @(negedge clk); data_data_ok = 1'b0; flush = 1'b1; #1;
    checks++;
    if ({ms_resp_valid, ms_resp_rdata} !== {1'b1, 32'h11112222}) begin
      failures++; $display("FAIL flush_resp_cur: valid=%b rdata=%h exp 1 11112222", ms_resp_valid, ms_resp_rdata);
    end
    @(negedge clk); flush = 1'b0; #1;
    checks++;
    if ({ms_resp_valid, es_req_ready} !== 2'b01) begin
      failures++; $display("FAIL flush_resp_discard: valid/ready=%b exp 01", {ms_resp_valid, es_req_ready});
    end
    ms_resp_ready = 1'b1;
  endtask

  task automatic test_reset_in_wait();
    issue(1'b1, SIZE_H, 32'h1c000802, 4'b1100, 32'hbeef0000);
    data_addr_ok = 1'b1;
    @(negedge clk); data_addr_ok = 1'b0; resetn = 1'b0; #1;
    checks++;
    if ({ms_resp_valid, es_req_ready} !== 2'b00) begin
      failures++; $display("FAIL rst_wait_comb: valid/ready=%b exp 00", {ms_resp_valid, es_req_ready});
    end
    @(negedge clk); #1;
    checks++;
    if ({data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata, ms_resp_valid, ms_resp_rdata} !== 104'd0) begin
      failures++; $display("FAIL rst_wait_outputs: req=%b addr=%h wdata=%h valid=%b", data_req, data_addr, data_wdata, ms_resp_valid);
    end
    resetn = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hffffffff; ms_resp_ready = 1'b1; #1;
    checks++;
    if ({ms_resp_valid, es_req_ready} !== 2'b01) begin
      failures++; $display("FAIL rst_late_data_ok: valid/ready=%b exp 01", {ms_resp_valid, es_req_ready});
    end
    @(negedge clk); data_data_ok = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; es_req_valid = 1'b0; es_req_wr = 1'b0; es_req_size = 2'd0;
    es_req_addr = '0; es_req_wstrb = '0; es_req_wdata = '0; ms_resp_ready = 1'b1;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    @(negedge clk);
    test_reset();
    @(negedge clk); test_load_bypass();
    @(negedge clk); test_load_stall();
    @(negedge clk); test_store();
    @(negedge clk); test_flush_idle();
    @(negedge clk); test_flush_req();
    @(negedge clk); test_addr_data_same();
    @(negedge clk); test_flush_wait_data_ok();
    @(negedge clk); test_flush_resp();
    @(negedge clk); test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
